// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port between instruction fetch (port 0)
// and data access (port 1), with a wait timeout that aborts a stuck cache access.
module cache_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdat0,
  input  logic [DW-1:0] wdat1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          cache_enab,
  output logic          cache_rw,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_data,
  input  logic [DW-1:0] cache_dout,
  input  logic          cache_hit
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          enab_q, enab_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  // Port 1 wins when it is the only requester, or when both request and port 0 went last.
  logic          sel1;
  assign sel1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    enab_d  = enab_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = sel1;
          rw_d    = sel1 ? rw1   : rw0;
          addr_d  = sel1 ? addr1 : addr0;
          data_d  = sel1 ? wdat1 : wdat0;
          enab_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
        // A hit on the final wait cycle still counts as a good completion.
        if (cache_hit) begin
          rdata_d = rw_q ? '0 : cache_dout;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        enab_d  = 1'b0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      enab_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      enab_q  <= enab_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign cache_enab = enab_q;
  assign cache_rw   = rw_q;
  assign cache_addr = addr_q;
  assign cache_data = data_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a table of single transactions plus
// hand-written sequences for fairness, reset during WAIT and initial reset.
module tb_cache_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          clr;
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdat0, wdat1;
  logic          ack0, ack1, err, busy;
  logic [DW-1:0] rdata;
  logic          cache_enab, cache_rw, cache_hit;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data, cache_dout;

  int nChecks = 0;
  int nFails  = 0;

  cache_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .cache_enab(cache_enab), .cache_rw(cache_rw), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_dout(cache_dout), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       port;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdat;
    int         hitEdge;
    logic       issueHit;
    logic [7:0] dout;
    logic [7:0] expRdata;
    logic       expErr;
    int         expLat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One transaction from a single requester; hitEdge counts clock edges after the grant edge.
  task automatic applyStimulus(input vec_t v);
    int   lat;
    int   holdErrs;
    logic seen;
    req0 = ~v.port;
    req1 = v.port;
    rw0   = v.port ? ~v.rw   : v.rw;
    rw1   = v.port ? v.rw    : ~v.rw;
    addr0 = v.port ? ~v.addr : v.addr;
    addr1 = v.port ? v.addr  : ~v.addr;
    wdat0 = v.port ? ~v.wdat : v.wdat;
    wdat1 = v.port ? v.wdat  : ~v.wdat;
    cache_hit  = 1'b0;
    cache_dout = v.dout;
    tick;
    checkOutput("grantEnab", cache_enab, 1);
    checkOutput("grantRw", cache_rw, v.rw);
    checkOutput("grantAddr", cache_addr, v.addr);
    checkOutput("grantData", cache_data, v.wdat);
    checkOutput("grantBusy", busy, 1);
    rw0 = ~rw0; rw1 = ~rw1;
    addr0 = ~addr0; addr1 = ~addr1;
    wdat0 = ~wdat0; wdat1 = ~wdat1;
    seen = 1'b0;
    lat = 0;
    holdErrs = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      cache_hit = (k == v.hitEdge) || (k == 1 && v.issueHit);
      tick;
      cache_hit = 1'b0;
      if (ack0 | ack1) begin
        seen = 1'b1;
        lat = k;
      end else if (cache_enab !== 1'b1 || cache_rw !== v.rw ||
                   cache_addr !== v.addr || cache_data !== v.wdat) begin
        holdErrs++;
      end
    end
    checkOutput("cacheHold", holdErrs, 0);
    checkOutput("ackSeen", seen, 1);
    checkOutput("latency", lat, v.expLat);
    checkOutput("ackPort", {ack1, ack0}, v.port ? 2'b10 : 2'b01);
    checkOutput("rdata", rdata, v.expRdata);
    checkOutput("err", err, v.expErr);
    checkOutput("busyAtAck", busy, 0);
    checkOutput("enabAtAck", cache_enab, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    checkOutput("ackPulse", {ack1, ack0}, 0);
    checkOutput("rdataHeld", rdata, v.expRdata);
  endtask

  initial begin
    int nAck;
    int bothErrs;
    int ackPort[4];
    int ackTime[4];
    int strayAcks;
    logic seen;

    //            port rw    addr   wdat   hitE issH dout   rdata  err  lat
    vecs[0] = '{1'b0, 1'b0, 8'h01, 8'h00, 2,  1'b0, 8'hE0, 8'hE0, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 8'h02, 8'hC0, 2,  1'b0, 8'h55, 8'h00, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b1, 8'h80, 8'h11, 4,  1'b0, 8'h99, 8'h00, 1'b0, 5};
    vecs[3] = '{1'b1, 1'b0, 8'h33, 8'h07, 5,  1'b0, 8'h7E, 8'h7E, 1'b0, 6};
    vecs[4] = '{1'b0, 1'b0, 8'hAA, 8'h00, 0,  1'b0, 8'h66, 8'h00, 1'b1, TIMEOUT + 2};
    vecs[5] = '{1'b1, 1'b0, 8'h44, 8'h00, TIMEOUT + 1, 1'b0, 8'h3C, 8'h3C, 1'b0, TIMEOUT + 2};
    vecs[6] = '{1'b0, 1'b0, 8'h10, 8'h00, 3,  1'b0, 8'hA5, 8'hA5, 1'b0, 4};
    vecs[7] = '{1'b1, 1'b0, 8'h5A, 8'h00, 3,  1'b1, 8'h6D, 8'h6D, 1'b0, 4};

    clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
    cache_hit = 1'b0; cache_dout = '0;
    tick;
    tick;
    checkOutput("rstOutputs", {ack0, ack1, err, busy, cache_enab, cache_rw}, 0);
    checkOutput("rstBuses", {rdata, cache_addr, cache_data}, 0);
    clr = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] fairness with both ports requesting");
    clr = 1'b1;
    tick;
    clr = 1'b0;
    req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = 8'h0A; addr1 = 8'h1B;
    cache_hit = 1'b1; cache_dout = 8'h3C;
    nAck = 0;
    bothErrs = 0;
    for (int k = 1; k <= 40 && nAck < 4; k++) begin
      tick;
      if (ack0 & ack1) bothErrs++;
      if (ack0 | ack1) begin
        ackPort[nAck] = ack1 ? 1 : 0;
        ackTime[nAck] = k;
        nAck++;
        if (nAck == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    cache_hit = 1'b0;
    checkOutput("fairCount", nAck, 4);
    checkOutput("fairBoth", bothErrs, 0);
    if (nAck == 4) begin
      checkOutput("fairOrder", {ackPort[0][1:0], ackPort[1][1:0], ackPort[2][1:0], ackPort[3][1:0]}, 8'b00_01_00_01);
      checkOutput("fairFirst", ackTime[0], 4);
      checkOutput("fairSpacing", {ackTime[1] - ackTime[0], ackTime[2] - ackTime[1], ackTime[3] - ackTime[2]}, {32'd4, 32'd4, 32'd4});
    end
    tick;

    $display("[TB] reset while waiting on the cache");
    applyStimulus(vecs[0]);
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h12;
    cache_hit = 1'b0;
    tick;
    tick;
    tick;
    checkOutput("preRstBusy", busy, 1);
    clr = 1'b1;
    req1 = 1'b0;
    tick;
    clr = 1'b0;
    checkOutput("rstEnab", cache_enab, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstRdata", rdata, 0);
    strayAcks = 0;
    for (int k = 0; k < 4; k++) begin
      if (ack0 | ack1) strayAcks++;
      tick;
    end
    checkOutput("rstNoAck", strayAcks, 0);
    req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = 8'h21; addr1 = 8'h12;
    tick;
    checkOutput("rstGrantAddr", cache_addr, 8'h21);
    req1 = 1'b0;
    cache_hit = 1'b1;
    cache_dout = 8'h4D;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick;
      if (ack0 | ack1) begin
        seen = 1'b1;
        req0 = 1'b0;
        checkOutput("rstGrantAck", {ack1, ack0}, 2'b01);
        checkOutput("rstGrantRdata", rdata, 8'h4D);
      end
    end
    cache_hit = 1'b0;
    checkOutput("rstGrantDone", seen, 1);
    tick;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
